fir_out_decimator: RTL
======================

# fir_out_decimator

Output stage placed directly downstream of the FIR filter top. It consumes `filtered_signal` one sample per valid cycle and discards the pipeline warm-up samples produced while the two tap shifters fill. It decimates the remaining stream by a programmable factor and buffers kept samples in a small first-word-fall-through FIFO. It then presents them to the downstream consumer over a valid/ready handshake and flags any sample lost to backpressure.

## Interface
- `DATA_W`, 16, sample width; matches `filtered_signal`.
- `FIFO_DEPTH`, 8, buffer entries; must be a power of two, at least 2.
- `WARMUP`, 30, number of accepted input samples discarded after reset (two 15-tap shifters).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `filtered_signal`  in  DATA_W  filter output sample.
- `in_valid`  in  1  `filtered_signal` holds a new sample this cycle.
- `decim`  in  4  decimation code; keep 1 of every `decim+1` samples (1..16).
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  DATA_W  FIFO head sample.
- `out_valid`  out  1  FIFO non-empty.
- `fill_level`  out  log2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
- `warm`  out  1  warm-up complete; kept samples now eligible.
- `overflow`  out  1  sticky; a kept sample was dropped because the FIFO was full.

## Operation
- Input accept occurs when `in_valid` is 1. Nothing happens on cycles with `in_valid` low.
- Warm-up:
  - Counter `wcnt` counts accepted samples while `warm`=0.
  - The first WARMUP accepted samples are discarded.
  - `warm` rises on the cycle after the WARMUP-th accept and stays 1 until `rst`.
- Decimation:
  - Phase counter `phase` (4 bit) advances only on accepted samples while `warm`=1.
  - A sample is kept when `phase`==0.
  - Next phase is 0 if `phase` >= `decim`, else `phase`+1.
  - `decim` is read live. Lowering it mid-phase wraps phase to 0 at the next accept. `phase` never exceeds 15.
- FIFO:
  - Circular buffer with read and write pointers plus a count.
  - A kept sample is pushed if count < FIFO_DEPTH, or if count == FIFO_DEPTH and a pop happens in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
- Pop: `out_valid` and `out_ready` both 1. The head advances and count decrements, unless a push happens in the same cycle, in which case count is unchanged.
- Pop is ignored when empty (`out_valid`=0). Pointers wrap modulo FIFO_DEPTH.
- Data is passed bit-exact: no rounding, saturation or sign change.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `fill_level`=0, `warm`=0, `overflow`=0. Internal counters and pointers are 0.
- `rst` is checked before any other condition. Asserting it mid-stream empties the FIFO and restarts warm-up on the next cycle.
- Latency: a sample kept at edge t is visible on `out_data` with `out_valid`=1 after edge t, i.e. one cycle, when the FIFO was empty.
- While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.
- `fill_level` and `out_valid` are registered and update on the same edge as the push or pop.
- `overflow` is set on the edge of the dropped push and is cleared only by `rst`.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- **Warm-up discard:** `decim`=0, `out_ready`=1, `in_valid`=1, samples 1,2,3,… → `out_data` 1..30 never appear. First `out_valid` shows 31. `warm` rises after the 30th accept.
- **Decimation:** `decim`=3 after warm-up, samples 100,101,… with `in_valid` every cycle → outputs 100,104,108,…. Changing `decim` to 1 while `phase`=2 → phase wraps to 0 on the next accept, and every 2nd sample is kept from then on.
- **Backpressure/overflow:** `decim`=0, `out_ready`=0, 10 kept samples → `fill_level` stops at 8 and `overflow`=1. Draining yields exactly the first 8 samples in order.
- **Full simultaneous push/pop:** FIFO at 8, `out_ready`=1 with a kept sample the same cycle → `fill_level` stays 8, `overflow` stays 0, and the new sample is last out.
- **Gapped input:** `in_valid` toggling 1,0,1,0 → phase and warm-up advance only on valid cycles, and the output matches the gap-free case.
- **Mid-stream reset:** `rst` pulsed for one cycle with the FIFO at 5 and `overflow`=1 → next cycle all outputs 0. The 30 following samples are discarded again.

Source files
------------

// File: rtl/fir_out_decimator_if.sv
// Sample stream from the FIR top into the output stage, plus the
// downstream valid/ready port and the status flags.
interface fir_out_decimator_if #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8
) ();
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_W-1:0] filtered_signal;
   logic              in_valid;
   logic [3:0]        decim;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic [CW-1:0]     fill_level;
   logic              warm;
   logic              overflow;

   // Producer / consumer side (testbench or surrounding logic)
   modport master (
      output filtered_signal, in_valid, decim, out_ready,
      input  out_data, out_valid, fill_level, warm, overflow
   );

   // Decimator side
   modport slave (
      input  filtered_signal, in_valid, decim, out_ready,
      output out_data, out_valid, fill_level, warm, overflow
   );
endinterface

// File: rtl/fir_out_decimator.sv
// FIR output stage: drop pipeline warm-up samples, keep 1 of every
// decim+1 samples, buffer kept samples in a FWFT FIFO and hand them
// downstream over valid/ready. Sticky overflow flags a lost sample.
module fir_out_decimator #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int WARMUP     = 30
) (
   input logic               clk,
   input logic               rst,
   fir_out_decimator_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(WARMUP + 1);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count, count_nxt;
   logic [WW-1:0]     wcnt;
   logic [3:0]        phase;
   logic              warm_q, ovf_q, vld_q;
   logic              keep, pop, push, drop;

   // A kept sample may enter a full FIFO only when the head leaves in the
   // same cycle; otherwise it is lost.
   assign keep = bus.in_valid & warm_q & (phase == 4'd0);
   assign pop  = vld_q & bus.out_ready;
   assign push = keep & ((count != CW'(FIFO_DEPTH)) | pop);
   assign drop = keep & ~push;

   // Next occupancy; simultaneous push and pop leave it unchanged
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Warm-up counter: discard the first WARMUP accepted samples
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt   <= '0;
         warm_q <= 1'b0;
      end else if (bus.in_valid && !warm_q) begin
         wcnt <= wcnt + WW'(1);
         if (wcnt == WW'(WARMUP - 1)) warm_q <= 1'b1;
      end
   end

   // Decimation phase; decim is read live so a lower value wraps at once
   always_ff @(posedge clk) begin
      if (rst)                         phase <= 4'd0;
      else if (bus.in_valid && warm_q) phase <= (phase >= bus.decim) ? 4'd0 : phase + 4'd1;
   end

   // FIFO storage, pointers, occupancy and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.filtered_signal;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (drop) ovf_q  <= 1'b1;
         count <= count_nxt;
         vld_q <= (count_nxt != '0);
      end
   end

   // Head of the FIFO is presented directly (first-word fall-through)
   assign bus.out_data   = mem[rd_ptr];
   assign bus.out_valid  = vld_q;
   assign bus.fill_level = count;
   assign bus.warm       = warm_q;
   assign bus.overflow   = ovf_q;
endmodule
